fp32_mul_seq: RTL and testbench

Sequential IEEE-754 single-precision multiplier for the Multiple2 datapath. It unpacks two fp32 operands and forms the 24×24 mantissa product with a radix-2 shift-and-add loop built on the team's ripple-carry adder cells. It then normalises, truncates and packs the result. The block sits between the operand registers and the result writeback, and uses a start/done handshake with fixed latency.

---
 rtl/fp32_mul_seq.sv | 196 +++++++++++++++++++
 tb/tb_fp32_mul_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: sequential fp32 multiplier, shift-and-add mantissa loop.
// Ports: clk/rst(sync,high), start/in1/in2 in; busy/done/result/overflow/underflow out.
module fp32_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_s;
  logic [7:0]  r_e1;
  logic [7:0]  r_e2;
  logic [23:0] r_a;
  logic [47:0] r_p;
  logic [4:0]  r_cnt;
  logic        r_zero;
  logic        r_inf;
  logic        r_nan;
  logic [9:0]  r_exp;
  logic [22:0] r_frac;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;

  logic [23:0] w_addend;
  logic [23:0] w_sum;
  logic        w_c;
  logic [9:0]  w_exp;
  logic        w_big;
  logic        w_small;
  logic        w_sel_nan;
  logic        w_sel_inf;
  logic        w_sel_zero;
  logic        w_sel_ovf;
  logic        w_sel_unf;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_unf;
  logic        w_z1;
  logic        w_z2;
  logic        w_i1;
  logic        w_i2;
  logic        w_n1;
  logic        w_n2;

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

  // Operand classification, denormals flushed to zero.
  assign w_z1 = (in1[30:23] == 8'd0);
  assign w_z2 = (in2[30:23] == 8'd0);
  assign w_i1 = (in1[30:23] == 8'hFF) && (in1[22:0] == 23'd0);
  assign w_i2 = (in2[30:23] == 8'hFF) && (in2[22:0] == 23'd0);
  assign w_n1 = (in1[30:23] == 8'hFF) && (in1[22:0] != 23'd0);
  assign w_n2 = (in2[30:23] == 8'hFF) && (in2[22:0] != 23'd0);

  assign w_addend = r_p[0] ? r_a : 24'd0;

  // 24-bit ripple-carry add of the upper product half and the addend.
  always_comb begin
    logic c;
    c     = 1'b0;
    w_sum = '0;
    for (int i = 0; i < 24; i++) begin
      w_sum[i] = r_p[24+i] ^ w_addend[i] ^ c;
      c = (r_p[24+i] & w_addend[i])
        | (c & (r_p[24+i] ^ w_addend[i]));
    end
    w_c = c;
  end

  // Biased exponent, 10-bit two's complement.
  assign w_exp = {2'b00, r_e1} + {2'b00, r_e2}
               - 10'd127 + {9'd0, r_p[47]};

  assign w_big   = !r_exp[9] && (r_exp >= 10'd255);
  assign w_small = r_exp[9] || (r_exp == 10'd0);

  // Mutually exclusive selects encode the result priority.
  assign w_sel_nan  = r_nan | (r_inf & r_zero);
  assign w_sel_inf  = !w_sel_nan & r_inf;
  assign w_sel_zero = !r_nan & !r_inf & r_zero;
  assign w_sel_ovf  = !r_nan & !r_inf & !r_zero & w_big;
  assign w_sel_unf  = !r_nan & !r_inf & !r_zero & w_small;

  always_comb begin
    w_res = {r_s, r_exp[7:0], r_frac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    unique case (1'b1)
      w_sel_nan:  w_res = 32'h7FC0_0000;
      w_sel_inf:  w_res = {r_s, 8'hFF, 23'd0};
      w_sel_zero: w_res = {r_s, 31'd0};
      w_sel_ovf: begin
        w_res = {r_s, 8'hFF, 23'd0};
        w_ovf = 1'b1;
      end
      w_sel_unf: begin
        w_res = {r_s, 31'd0};
        w_unf = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_MUL;
      S_MUL:  if (r_cnt == 5'd23) w_next = S_NORM;
      S_NORM: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s      <= 1'b0;
      r_e1     <= '0;
      r_e2     <= '0;
      r_a      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_inf    <= 1'b0;
      r_nan    <= 1'b0;
      r_exp    <= '0;
      r_frac   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_s    <= in1[31] ^ in2[31];
          r_e1   <= in1[30:23];
          r_e2   <= in2[30:23];
          r_a    <= {1'b1, in1[22:0]};
          r_p    <= {24'd0, 1'b1, in2[22:0]};
          r_cnt  <= '0;
          r_zero <= w_z1 | w_z2;
          r_inf  <= w_i1 | w_i2;
          r_nan  <= w_n1 | w_n2;
          r_busy <= 1'b1;
        end
        S_MUL: begin
          r_p   <= {w_c, w_sum, r_p[23:1]};
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: begin
          r_exp  <= w_exp;
          r_frac <= r_p[47] ? r_p[46:24] : r_p[45:23];
        end
        S_DONE: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb_fp32_mul_seq: directed vector bench for fp32_mul_seq.
// Table of products plus handshake, back-to-back and reset sequences.
module tb_fp32_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  fp32_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input  logic [31:0] a,
                       input  logic [31:0] b,
                       input  bit          sync,
                       output logic [31:0] r,
                       output logic        ov,
                       output logic        un,
                       output int          lat,
                       output logic        bz);
    if (sync) @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bz    = busy;
    in1   = $urandom;
    in2   = $urandom;
    lat   = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = result;
    ov = overflow;
    un = underflow;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        ov;
    logic        un;
    logic        bz;
    logic [31:0] got;
    int          lat;
    int          nd;

    tv[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0};
    tv[1]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0};
    tv[2]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0};
    tv[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 0, 0};
    tv[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0};
    tv[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 0, 1};
    tv[6]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 0, 0};
    tv[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0};
    tv[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0};
    tv[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 0, 0};
    tv[10] = '{32'h40000000, 32'hBF000000, 32'hBF800000, 0, 0};
    tv[11] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0};

    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_unf", {31'd0, underflow}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(tv[i].a, tv[i].b, 1'b1, r, ov, un, lat, bz);
      chk($sformatf("v%0d_res", i), r, tv[i].r);
      chk($sformatf("v%0d_ovf", i), {31'd0, ov}, {31'd0, tv[i].ov});
      chk($sformatf("v%0d_unf", i), {31'd0, un}, {31'd0, tv[i].un});
      chk($sformatf("v%0d_lat", i), lat, 26);
      chk($sformatf("v%0d_busy", i), {31'd0, bz}, 32'd1);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
    end

    // start pulses while busy must be ignored
    @(negedge clk);
    in1   = 32'h3FC00000;
    in2   = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd    = 0;
    got   = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        got = result;
      end
      start = (c == 4 || c == 19);
      in1   = 32'h7F000000;
      in2   = 32'h7F000000;
    end
    start = 1'b0;
    chk("hs_dones", nd, 1);
    chk("hs_res", got, 32'h40400000);

    // back-to-back at the minimum interval
    do_op(32'h40000000, 32'h40400000, 1'b1, r, ov, un, lat, bz);
    chk("b2b0_res", r, 32'h40C00000);
    do_op(32'hC0400000, 32'h40400000, 1'b0, r, ov, un, lat, bz);
    chk("b2b1_busy", {31'd0, bz}, 32'd1);
    chk("b2b1_lat", lat, 26);
    chk("b2b1_res", r, 32'hC1100000);

    // reset during the MUL loop aborts the op
    @(negedge clk);
    in1   = 32'h40000000;
    in2   = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    do_op(32'h40000000, 32'h40400000, 1'b1, r, ov, un, lat, bz);
    chk("post_abort_res", r, 32'h40C00000);
    chk("post_abort_lat", lat, 26);

    // reset and start together: reset wins
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    in1   = 32'h3F800000;
    in2   = 32'h3F800000;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_start_busy2", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
